// File: rtl/truth_table_checker.sv
// ---------------------------------------------------------------------------
// truth_table_checker
//
// Drives every input combination of a small N_IN-input combinational (or
// shallowly registered) gate in binary order. Each vector is held for
// SETTLE_CYCLES cycles plus one sample cycle. At the end of the sample cycle
// the gate output is compared with TRUTH[vec_out]. The block then reports
// pass/fail, the mismatch count and the first failing vector.
//
// Ports:
//   clk             system clock, rising edge
//   rst_n           asynchronous active-low reset
//   start           begin a run; only honoured in IDLE or DONE
//   vec_out         [N_IN]   stimulus to the gate under test (MSB = input a)
//   dut_out         response of the gate under test
//   busy            run in progress (SETTLE/SAMPLE)
//   done            run complete; held until the next accepted start
//   pass            done with zero mismatches
//   err_count       [N_IN+1] mismatching vectors in the last/current run
//   first_err_valid at least one mismatch recorded this run
//   first_err_vec   [N_IN]   index of the first mismatching vector
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | out of reset, waiting for start
// SETTLE | holding vec_out while the gate output settles
// SAMPLE | single cycle; dut_out is compared at its ending edge
// DONE   | results frozen; start begins a new run
// ---------------------------------------------------------------------------
module truth_table_checker #(
  parameter int unsigned               N_IN          = 3,
  parameter logic [(2**N_IN)-1:0]      TRUTH         = 8'b1000_0000,
  parameter int unsigned               SETTLE_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] vec_out,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            first_err_valid,
  output logic [N_IN-1:0] first_err_vec
);

  // Counter only needs to reach SETTLE_CYCLES-1.
  localparam int unsigned     CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [N_IN-1:0] VEC_LAST = '1;
  localparam logic [N_IN-1:0] VEC_ONE  = N_IN'(1);
  localparam logic [N_IN:0]   ERR_ONE  = (N_IN + 1)'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] settle_cnt, settle_cnt_nxt;
  logic [N_IN-1:0]  vec_nxt;
  logic [N_IN:0]    err_nxt;
  logic             fev_valid_nxt;
  logic [N_IN-1:0]  fev_nxt;
  logic             mismatch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      settle_cnt      <= '0;
      vec_out         <= '0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_vec   <= '0;
    end else begin
      state           <= state_nxt;
      settle_cnt      <= settle_cnt_nxt;
      vec_out         <= vec_nxt;
      err_count       <= err_nxt;
      first_err_valid <= fev_valid_nxt;
      first_err_vec   <= fev_nxt;
    end
  end

  assign mismatch = (dut_out != TRUTH[vec_out]);

  always_comb begin
    state_nxt      = state;
    settle_cnt_nxt = settle_cnt;
    vec_nxt        = vec_out;
    err_nxt        = err_count;
    fev_valid_nxt  = first_err_valid;
    fev_nxt        = first_err_vec;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt      = SETTLE;
          settle_cnt_nxt = '0;
          vec_nxt        = '0;
          err_nxt        = '0;
          fev_valid_nxt  = 1'b0;
          fev_nxt        = '0;
        end
      end
      SETTLE: begin
        if (settle_cnt == CNT_LAST) begin
          state_nxt      = SAMPLE;
          settle_cnt_nxt = '0;
        end else begin
          settle_cnt_nxt = settle_cnt + CNT_ONE;
        end
      end
      SAMPLE: begin
        if (mismatch) begin
          err_nxt = err_count + ERR_ONE;
          if (!first_err_valid) begin
            fev_valid_nxt = 1'b1;
            fev_nxt       = vec_out;
          end
        end
        // Terminate on all-ones rather than relying on the counter wrapping.
        if (vec_out == VEC_LAST) begin
          state_nxt = DONE;
          vec_nxt   = '0;
        end else begin
          state_nxt = SETTLE;
          vec_nxt   = vec_out + VEC_ONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == SETTLE) || (state == SAMPLE);
  assign done = (state == DONE);
  assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_truth_table_checker.sv
module tb_truth_table_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start0, start1;
  int         mode0, mode1;   // 0 = AND, 1 = tied 0, 2 = tied 1, 3 = OR

  logic [2:0] vec0, vec1, fev0, fev1;
  logic [3:0] err0, err1;
  logic       busy0, busy1, done0, done1, pass0, pass1, fv0, fv1;
  logic       dut0_out, dut1_out, reg_and;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  truth_table_checker u_chk0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .vec_out(vec0), .dut_out(dut0_out),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .first_err_valid(fv0), .first_err_vec(fev0)
  );

  truth_table_checker #(.N_IN(3), .TRUTH(8'b1000_0000), .SETTLE_CYCLES(1)) u_chk1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .vec_out(vec1), .dut_out(dut1_out),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_err_valid(fv1), .first_err_vec(fev1)
  );

  always_comb begin
    case (mode0)
      0:       dut0_out = &vec0;
      1:       dut0_out = 1'b0;
      2:       dut0_out = 1'b1;
      3:       dut0_out = |vec0;
      default: dut0_out = 1'b0;
    endcase
  end

  // Registered AND gate with one cycle of latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) reg_and <= 1'b0;
    else        reg_and <= &vec1;
  end
  assign dut1_out = (mode1 == 1) ? 1'b0 : reg_and;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Starts a run on checker 0 or 1 and counts edges from the accepting edge
  // to the edge that sets done. vec_bad counts cycles where vec_out differs
  // from cycles/hold. Optionally re-pulses start while busy.
  task automatic run(input int sel, input int mode, input int repulse_at,
                     output int cycles, output int vec_bad,
                     output int err_at_accept, output int done_at_accept);
    int hold;
    hold = (sel == 0) ? 3 : 2;
    if (sel == 0) mode0 = mode; else mode1 = mode;
    @(negedge clk);
    if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
    err_at_accept  = (sel == 0) ? int'(err0)  : int'(err1);
    done_at_accept = (sel == 0) ? int'(done0) : int'(done1);
    cycles  = 0;
    vec_bad = 0;
    while (!((sel == 0) ? done0 : done1) && cycles < 200) begin
      if (((sel == 0) ? vec0 : vec1) != 3'(cycles / hold)) vec_bad++;
      if (sel == 0) start0 = (cycles == repulse_at);
      @(posedge clk);
      #1;
      cycles++;
    end
    start0 = 1'b0;
  endtask

  initial begin
    int cyc, vbad, ea, da;
    rst_n  = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    mode0  = 0;
    mode1  = 0;
    #1;
    check("rst_vec",   32'(vec0),  0);
    check("rst_busy",  32'(busy0), 0);
    check("rst_done",  32'(done0), 0);
    check("rst_pass",  32'(pass0), 0);
    check("rst_err",   32'(err0),  0);
    check("rst_fv",    32'(fv0),   0);
    check("rst_fev",   32'(fev0),  0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Correct AND gate
    run(0, 0, -1, cyc, vbad, ea, da);
    check("and_cycles",  32'(cyc),   24);
    check("and_vec_seq", 32'(vbad),  0);
    check("and_pass",    32'(pass0), 1);
    check("and_err",     32'(err0),  0);
    check("and_fv",      32'(fv0),   0);
    check("and_busy",    32'(busy0), 0);
    check("and_vec_end", 32'(vec0),  0);
    repeat (4) @(posedge clk);
    #1;
    check("and_hold_done", 32'(done0), 1);

    // Tied 0
    run(0, 1, -1, cyc, vbad, ea, da);
    check("t0_cycles", 32'(cyc),   24);
    check("t0_err",    32'(err0),  1);
    check("t0_fev",    32'(fev0),  7);
    check("t0_fv",     32'(fv0),   1);
    check("t0_pass",   32'(pass0), 0);

    // Tied 1: restart from DONE clears previous results
    run(0, 2, -1, cyc, vbad, ea, da);
    check("t1_clr_err",  32'(ea),   0);
    check("t1_clr_done", 32'(da),   0);
    check("t1_err",      32'(err0), 7);
    check("t1_fev",      32'(fev0), 0);
    check("t1_fv",       32'(fv0),  1);

    // OR gate
    run(0, 3, -1, cyc, vbad, ea, da);
    check("or_err",  32'(err0),  6);
    check("or_fev",  32'(fev0),  1);
    check("or_pass", 32'(pass0), 0);

    // start re-pulsed while busy
    run(0, 0, 5, cyc, vbad, ea, da);
    check("repulse_cycles", 32'(cyc),   24);
    check("repulse_seq",    32'(vbad),  0);
    check("repulse_pass",   32'(pass0), 1);

    // Reset mid-run (tied 1 so partial errors exist)
    mode0 = 2;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("mid_err_before", 32'(err0), 3);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_vec",  32'(vec0),  0);
    check("mid_rst_busy", 32'(busy0), 0);
    check("mid_rst_err",  32'(err0),  0);
    check("mid_rst_fv",   32'(fv0),   0);
    check("mid_rst_fev",  32'(fev0),  0);
    check("mid_rst_done", 32'(done0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(0, 0, -1, cyc, vbad, ea, da);
    check("post_rst_cycles", 32'(cyc),   24);
    check("post_rst_pass",   32'(pass0), 1);

    // Registered AND, SETTLE_CYCLES = 1
    run(1, 0, -1, cyc, vbad, ea, da);
    check("reg_cycles",  32'(cyc),   16);
    check("reg_vec_seq", 32'(vbad),  0);
    check("reg_pass",    32'(pass1), 1);
    run(1, 1, -1, cyc, vbad, ea, da);
    check("reg_t0_err",  32'(err1),  1);
    run(1, 1, -1, cyc, vbad, ea, da);
    check("reg_t0_clr",    32'(ea),    0);
    check("reg_t0_cycles", 32'(cyc),   16);
    check("reg_t0_err2",   32'(err1),  1);
    check("reg_t0_fev",    32'(fev1),  7);
    check("reg_t0_pass",   32'(pass1), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
